// File: rtl/ram_arbiter.sv
// Shares the SDRAM command port between the camera write stream and two read clients (rd0, rd1).
// A grant is registered in IDLE and held in ISSUE until mem_ready. The camera is stalled by cam_busy and readers wait for rdN_ack.
module ram_arbiter #(
    parameter int AW         = 25,
    parameter int DW         = 128,
    parameter int WR_STREAK  = 8,
    parameter int MAX_RD_OUT = 4
) (
    input  logic          clk_133M,
    input  logic          rst_n_133M,
    input  logic          cam_wr_req,
    input  logic [AW-1:0] cam_wr_addr,
    input  logic [DW-1:0] cam_wr_data,
    input  logic [2:0]    cam_last_frm,
    input  logic          cam_frm_done,
    output logic          cam_busy,
    input  logic          rd0_req,
    input  logic [AW-1:0] rd0_addr,
    output logic          rd0_ack,
    output logic          rd0_valid,
    output logic [DW-1:0] rd0_data,
    input  logic          rd1_req,
    input  logic [AW-1:0] rd1_addr,
    output logic          rd1_ack,
    output logic          rd1_valid,
    output logic [DW-1:0] rd1_data,
    output logic          mem_cmd_valid,
    output logic          mem_cmd_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rd_valid,
    input  logic [DW-1:0] mem_rd_data,
    output logic          frame_done,
    output logic [2:0]    last_frame,
    output logic          wr_overflow
);

    localparam int SW = $clog2(WR_STREAK + 1);
    localparam int TW = $clog2(MAX_RD_OUT);

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t state_q, state_d;

    logic                  hold_vld_q;
    logic [AW-1:0]         hold_addr_q;
    logic [DW-1:0]         hold_data_q;
    logic [2:0]            hold_frm_q;
    logic                  hold_done_q;

    logic                  cmd_we_q;
    logic [AW-1:0]         cmd_addr_q;
    logic [DW-1:0]         cmd_wdata_q;
    logic                  cmd_client_q;

    logic [SW-1:0]         streak_q, streak_d;
    logic                  rr_q, rr_d;

    logic                  wr_overflow_q;
    logic                  frame_done_q;
    logic [2:0]            last_frame_q;
    logic [1:0]            rd_vld_q;
    logic [DW-1:0]         rd_data_q;

    logic [MAX_RD_OUT-1:0] tag_mem_q;
    logic [TW:0]           tag_wr_q;
    logic [TW:0]           tag_rd_q;

    logic                  accept;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  rd_pend;
    logic                  streak_full;
    logic                  rr_pick;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  tag_push;
    logic                  tag_pop;
    logic                  tag_client;
    logic                  hold_load;

    logic                  grant_vld;
    logic                  grant_we;
    logic                  grant_client;
    logic [AW-1:0]         grant_addr;

    assign accept      = (state_q == S_ISSUE) && mem_ready;
    assign wr_accept   = accept && cmd_we_q;
    assign rd_accept   = accept && !cmd_we_q;
    assign rd_pend     = rd0_req || rd1_req;
    assign streak_full = (streak_q == SW'(WR_STREAK));

    // rr_q names the client to favour; fall back to the other one when it is idle.
    assign rr_pick     = rr_q ? rd1_req : !rd0_req;

    assign tag_full    = ((tag_wr_q ^ tag_rd_q) == {1'b1, {TW{1'b0}}});
    assign tag_empty   = (tag_wr_q == tag_rd_q);
    assign tag_pop     = mem_rd_valid && !tag_empty;
    assign tag_push    = rd_accept && (!tag_full || tag_pop);
    assign tag_client  = tag_mem_q[tag_rd_q[TW-1:0]];

    // The holding register is released by a write accept before the new capture is considered.
    assign hold_load   = cam_wr_req && (!hold_vld_q || wr_accept);

    always_comb begin
        state_d      = state_q;
        grant_vld    = 1'b0;
        grant_we     = 1'b0;
        grant_client = rr_pick;
        grant_addr   = rr_pick ? rd1_addr : rd0_addr;
        case (state_q)
            S_IDLE: begin
                if (rd_pend && streak_full && !tag_full) begin
                    grant_vld = 1'b1;
                end else if (hold_vld_q) begin
                    grant_vld  = 1'b1;
                    grant_we   = 1'b1;
                    grant_addr = hold_addr_q;
                end else if (rd_pend && !tag_full) begin
                    grant_vld = 1'b1;
                end
                if (grant_vld) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        streak_d = streak_q;
        rr_d     = rr_q;
        if (rd_accept || !rd_pend) begin
            streak_d = '0;
        end else if (wr_accept && !streak_full) begin
            streak_d = streak_q + 1'b1;
        end
        if (rd_accept) begin
            rr_d = !cmd_client_q;
        end
    end

    always_ff @(posedge clk_133M) begin
        if (!rst_n_133M) begin
            state_q       <= S_IDLE;
            hold_vld_q    <= 1'b0;
            hold_addr_q   <= '0;
            hold_data_q   <= '0;
            hold_frm_q    <= '0;
            hold_done_q   <= 1'b0;
            cmd_we_q      <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= '0;
            cmd_client_q  <= 1'b0;
            streak_q      <= '0;
            rr_q          <= 1'b0;
            wr_overflow_q <= 1'b0;
            frame_done_q  <= 1'b0;
            last_frame_q  <= '0;
            rd_vld_q      <= '0;
            rd_data_q     <= '0;
            tag_mem_q     <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            rr_q     <= rr_d;

            if (hold_load) begin
                hold_vld_q  <= 1'b1;
                hold_addr_q <= cam_wr_addr;
                hold_data_q <= cam_wr_data;
                hold_frm_q  <= cam_last_frm;
                hold_done_q <= cam_frm_done;
            end else if (wr_accept) begin
                hold_vld_q <= 1'b0;
            end

            if (cam_wr_req && hold_vld_q && !wr_accept) begin
                wr_overflow_q <= 1'b1;
            end

            frame_done_q <= wr_accept && hold_done_q;
            if (wr_accept && hold_done_q) begin
                last_frame_q <= hold_frm_q;
            end

            if (grant_vld) begin
                cmd_we_q     <= grant_we;
                cmd_addr_q   <= grant_addr;
                cmd_wdata_q  <= hold_data_q;
                cmd_client_q <= grant_client;
            end

            if (tag_push) begin
                tag_mem_q[tag_wr_q[TW-1:0]] <= cmd_client_q;
                tag_wr_q                    <= tag_wr_q + 1'b1;
            end
            if (tag_pop) begin
                tag_rd_q  <= tag_rd_q + 1'b1;
                rd_data_q <= mem_rd_data;
            end
            rd_vld_q <= {tag_pop && tag_client, tag_pop && !tag_client};
        end
    end

    assign cam_busy      = hold_vld_q;
    assign wr_overflow   = wr_overflow_q;
    assign frame_done    = frame_done_q;
    assign last_frame    = last_frame_q;

    assign mem_cmd_valid = (state_q == S_ISSUE);
    assign mem_cmd_we    = cmd_we_q;
    assign mem_addr      = cmd_addr_q;
    assign mem_wdata     = cmd_wdata_q;

    assign rd0_ack       = rd_accept && !cmd_client_q;
    assign rd1_ack       = rd_accept && cmd_client_q;
    assign rd0_valid     = rd_vld_q[0];
    assign rd1_valid     = rd_vld_q[1];
    assign rd0_data      = rd_data_q;
    assign rd1_data      = rd_data_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a small controller model returns reads in order, and every check is an immediate assertion.
module tb_ram_arbiter;

    localparam int AW = 25;
    localparam int DW = 128;

    logic          clk_133M     = 1'b0;
    logic          rst_n_133M   = 1'b0;
    logic          cam_wr_req   = 1'b0;
    logic [AW-1:0] cam_wr_addr  = '0;
    logic [DW-1:0] cam_wr_data  = '0;
    logic [2:0]    cam_last_frm = '0;
    logic          cam_frm_done = 1'b0;
    logic          cam_busy;
    logic          rd0_req      = 1'b0;
    logic [AW-1:0] rd0_addr     = '0;
    logic          rd0_ack;
    logic          rd0_valid;
    logic [DW-1:0] rd0_data;
    logic          rd1_req      = 1'b0;
    logic [AW-1:0] rd1_addr     = '0;
    logic          rd1_ack;
    logic          rd1_valid;
    logic [DW-1:0] rd1_data;
    logic          mem_cmd_valid;
    logic          mem_cmd_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready    = 1'b0;
    logic          mem_rd_valid = 1'b0;
    logic [DW-1:0] mem_rd_data  = '0;
    logic          frame_done;
    logic [2:0]    last_frame;
    logic          wr_overflow;

    int            n_cmp      = 0;
    int            n_bad      = 0;
    int            wr_acc     = 0;
    int            ret_budget = 0;
    int            wr_before;
    logic [AW-1:0] pend_q[$];
    int            ack_seq[$];
    logic [DW-1:0] got0[$];
    logic [DW-1:0] got1[$];

    ram_arbiter dut (
        .clk_133M     (clk_133M),
        .rst_n_133M   (rst_n_133M),
        .cam_wr_req   (cam_wr_req),
        .cam_wr_addr  (cam_wr_addr),
        .cam_wr_data  (cam_wr_data),
        .cam_last_frm (cam_last_frm),
        .cam_frm_done (cam_frm_done),
        .cam_busy     (cam_busy),
        .rd0_req      (rd0_req),
        .rd0_addr     (rd0_addr),
        .rd0_ack      (rd0_ack),
        .rd0_valid    (rd0_valid),
        .rd0_data     (rd0_data),
        .rd1_req      (rd1_req),
        .rd1_addr     (rd1_addr),
        .rd1_ack      (rd1_ack),
        .rd1_valid    (rd1_valid),
        .rd1_data     (rd1_data),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_we   (mem_cmd_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .frame_done   (frame_done),
        .last_frame   (last_frame),
        .wr_overflow  (wr_overflow)
    );

    always #5 clk_133M = ~clk_133M;

    function automatic logic [DW-1:0] mk(input logic [AW-1:0] a);
        return {{(DW-AW-8){1'b0}}, 8'hD0, a};
    endfunction

    // Controller model: returns the oldest accepted read (never in its own accept cycle) while budget remains.
    always @(negedge clk_133M) begin
        if (rd0_valid) got0.push_back(rd0_data);
        if (rd1_valid) got1.push_back(rd1_data);
        mem_rd_valid = 1'b0;
        if (ret_budget > 0 && pend_q.size() > 0) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mk(pend_q.pop_front());
            ret_budget--;
        end
        if (mem_cmd_valid && mem_ready) begin
            if (mem_cmd_we) begin
                wr_acc++;
                ack_seq.push_back(2);
            end else begin
                pend_q.push_back(mem_addr);
                ack_seq.push_back(rd0_ack ? 0 : (rd1_ack ? 1 : 3));
            end
        end
    end

    task automatic tick();
        @(posedge clk_133M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_busy", cam_busy, 0);
        chk("rst_cmd_valid", mem_cmd_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_last_frame", last_frame, 0);
        chk("rst_overflow", wr_overflow, 0);
        chk("rst_rd0_valid", rd0_valid, 0);
        rst_n_133M = 1'b1;
        tick();

        // 1. Single write closing frame slot 2
        mem_ready    = 1'b1;
        cam_wr_req   = 1'b1;
        cam_wr_addr  = 25'h100;
        cam_wr_data  = 128'hCAFE_0001;
        cam_frm_done = 1'b1;
        cam_last_frm = 3'd2;
        tick();
        cam_wr_req   = 1'b0;
        cam_frm_done = 1'b0;
        chk("t1_busy_rise", cam_busy, 1);
        chk("t1_no_cmd_yet", mem_cmd_valid, 0);
        tick();
        chk("t1_cmd_valid", mem_cmd_valid, 1);
        chk("t1_cmd_we", mem_cmd_we, 1);
        chk("t1_cmd_addr", mem_addr, 25'h100);
        chk("t1_cmd_wdata", mem_wdata, 128'hCAFE_0001);
        tick();
        chk("t1_frame_done", frame_done, 1);
        chk("t1_last_frame", last_frame, 2);
        chk("t1_busy_fall", cam_busy, 0);
        chk("t1_idle", mem_cmd_valid, 0);
        tick();
        chk("t1_frame_done_pulse", frame_done, 0);
        chk("t1_wr_acc", wr_acc, 1);

        // 2. Both readers held, no writes: strict alternation starting at rd0
        ack_seq.delete();
        got0.delete();
        got1.delete();
        ret_budget = 1000;
        rd0_req  = 1'b1;
        rd0_addr = 25'h200;
        rd1_req  = 1'b1;
        rd1_addr = 25'h300;
        repeat (12) tick();
        rd0_req = 1'b0;
        rd1_req = 1'b0;
        repeat (8) tick();
        chk("t2_enough_acks", ack_seq.size() >= 5, 1);
        for (int i = 0; i < ack_seq.size(); i++) chk("t2_ack_order", ack_seq[i], i % 2);
        chk("t2_n_rd0", got0.size(), (ack_seq.size() + 1) / 2);
        chk("t2_n_rd1", got1.size(), ack_seq.size() / 2);
        foreach (got0[i]) chk("t2_rd0_data", got0[i], mk(25'h200));
        foreach (got1[i]) chk("t2_rd1_data", got1[i], mk(25'h300));

        // 3. Back-to-back writes with rd0 held: 8 writes, then one read
        ack_seq.delete();
        cam_wr_req  = 1'b1;
        cam_wr_addr = 25'h1000;
        tick();
        cam_wr_req = 1'b0;
        rd0_req    = 1'b1;
        rd0_addr   = 25'h400;
        for (int i = 0; i < 300 && ack_seq.size() < 18; i++) begin
            cam_wr_req = !cam_busy || (mem_cmd_valid && mem_ready && mem_cmd_we);
            if (cam_wr_req) begin
                cam_wr_addr = cam_wr_addr + 1'b1;
                cam_wr_data = cam_wr_data + 1'b1;
            end
            tick();
        end
        cam_wr_req = 1'b0;
        rd0_req    = 1'b0;
        repeat (8) tick();
        chk("t3_n_grants", ack_seq.size() >= 18, 1);
        for (int i = 0; i < 18; i++) chk("t3_grant_seq", ack_seq[i], (i % 9 == 8) ? 0 : 2);
        chk("t3_no_overflow", wr_overflow, 0);

        // 4. Returns withheld: tag FIFO caps outstanding reads at 4
        ack_seq.delete();
        got0.delete();
        got1.delete();
        ret_budget = 0;
        rd0_req  = 1'b1;
        rd0_addr = 25'h500;
        rd1_req  = 1'b1;
        rd1_addr = 25'h510;
        repeat (20) tick();
        chk("t4_four_out", ack_seq.size(), 4);
        ret_budget = 1;
        repeat (8) tick();
        chk("t4_fifth_after_return", ack_seq.size(), 5);
        rd0_req = 1'b0;
        rd1_req = 1'b0;
        ret_budget = 100;
        repeat (10) tick();
        chk("t4_all_returned", got0.size() + got1.size(), 5);

        // 5. Stalled command stays stable; a write during the stall overflows
        mem_ready    = 1'b0;
        wr_before    = wr_acc;
        cam_wr_req   = 1'b1;
        cam_wr_addr  = 25'h555;
        cam_wr_data  = 128'h5555_AAAA;
        cam_frm_done = 1'b0;
        tick();
        cam_wr_req = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t5_valid_held", mem_cmd_valid, 1);
            chk("t5_addr_stable", mem_addr, 25'h555);
            chk("t5_wdata_stable", mem_wdata, 128'h5555_AAAA);
            cam_wr_req  = (i == 3);
            cam_wr_addr = 25'h666;
            cam_wr_data = 128'h6666;
            tick();
        end
        cam_wr_req = 1'b0;
        chk("t5_overflow", wr_overflow, 1);
        chk("t5_busy_held", cam_busy, 1);
        mem_ready = 1'b1;
        tick();
        chk("t5_busy_free", cam_busy, 0);
        chk("t5_overflow_sticky", wr_overflow, 1);
        repeat (4) tick();
        chk("t5_one_write", wr_acc, wr_before + 1);

        // 6. Reset during ISSUE with two reads in flight
        ack_seq.delete();
        got0.delete();
        got1.delete();
        ret_budget = 0;
        rd0_req  = 1'b1;
        rd0_addr = 25'h600;
        rd1_req  = 1'b1;
        rd1_addr = 25'h700;
        for (int i = 0; i < 40 && ack_seq.size() < 2; i++) tick();
        chk("t6_two_out", ack_seq.size(), 2);
        mem_ready = 1'b0;
        tick();
        chk("t6_in_issue", mem_cmd_valid, 1);
        rst_n_133M = 1'b0;
        tick();
        chk("t6_cmd_valid", mem_cmd_valid, 0);
        chk("t6_cmd_we", mem_cmd_we, 0);
        chk("t6_addr", mem_addr, 0);
        chk("t6_wdata", mem_wdata, 0);
        chk("t6_busy", cam_busy, 0);
        chk("t6_acks", {rd0_ack, rd1_ack}, 0);
        chk("t6_valids", {rd0_valid, rd1_valid}, 0);
        chk("t6_rd_data", rd0_data, 0);
        chk("t6_overflow", wr_overflow, 0);
        chk("t6_last_frame", last_frame, 0);
        chk("t6_frame_done", frame_done, 0);
        rst_n_133M = 1'b1;
        rd0_req    = 1'b0;
        rd1_req    = 1'b0;
        ret_budget = 2;
        repeat (6) tick();
        chk("t6_stale_ignored", got0.size() + got1.size(), 0);

        // A fresh read after reset is granted to rd0 and routed correctly
        mem_ready  = 1'b1;
        ret_budget = 10;
        rd0_req    = 1'b1;
        rd0_addr   = 25'h800;
        for (int i = 0; i < 40 && ack_seq.size() < 3; i++) tick();
        rd0_req = 1'b0;
        repeat (6) tick();
        chk("t6_fresh_ack", ack_seq.size(), 3);
        chk("t6_fresh_client", ack_seq[ack_seq.size() - 1], 0);
        chk("t6_fresh_n", got0.size(), 1);
        chk("t6_fresh_data", got0[0], mk(25'h800));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
